// File: rtl/dict_load_pkg.sv
// Shared types and constants for the dictionary load sequencer: FSM states,
// image word field offsets, bloom hash constant and the 41-bit table entry layout.
package dict_load_pkg;

    typedef enum logic [3:0] {
        IDLE,
        OCC_CLR,
        FETCH0,
        WAIT0,
        FETCH1,
        WAIT1,
        PLACE,
        BLM1,
        BLM2,
        BLM3,
        NEXT,
        FIN
    } dls_state_t;

    localparam int W0_HASH_LSB = 0;
    localparam int W0_CHAR_LSB = 16;
    localparam int W1_PTR_LSB  = 0;

    localparam logic [15:0] BLOOM_XOR_CONST = 16'h5A5A;

    typedef struct packed {
        logic        valid;
        logic [15:0] hash;
        logic [7:0]  char_code;
        logic [15:0] trans_ptr;
    } dict_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bucket_occ_ram.sv
// Per-bucket occupancy counters: one asynchronous read port, one synchronous write port.
module bucket_occ_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 3
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dict_load_sequencer.sv
// Streams dictionary entries from memory into the hash table and bloom filter.
// Define DLS_TABLE_CLEAR_EN to also zero every table slot and bloom bit before loading.
module dict_load_sequencer
    import dict_load_pkg::*;
#(
    parameter int BLOOM_ADDR_BITS = 10,
    parameter int TABLE_ADDR_BITS = 8,
    parameter int CHAIN_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] base_addr,
    input  logic [15:0] entry_count,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] entries_loaded,
    output logic [15:0] entries_dropped,
    output logic        lookup_hold,
    output logic        mem_rd,
    output logic [23:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        dict_load_en,
    output logic [15:0] dict_load_addr,
    output logic [40:0] dict_load_data,
    output logic        bloom_load_en,
    output logic [15:0] bloom_load_addr,
    output logic        bloom_load_bit
);

    localparam int CD_BITS   = $clog2(CHAIN_DEPTH);
    localparam int OCC_W     = CD_BITS + 1;
    localparam int SLOT_BITS = TABLE_ADDR_BITS + CD_BITS;
    localparam int CLR_W     = (SLOT_BITS > BLOOM_ADDR_BITS) ? SLOT_BITS : BLOOM_ADDR_BITS;
    localparam logic [15:0] BLOOM_MASK = 16'((1 << BLOOM_ADDR_BITS) - 1);

    dls_state_t  state;
    logic [23:0] rd_ptr;
    logic [15:0] cnt_lat;
    logic [15:0] proc_cnt;
    logic [15:0] hash_q;
    logic [7:0]  char_q;
    logic [15:0] ptr_q;
    logic [CLR_W-1:0] clr_cnt;
`ifdef DLS_TABLE_CLEAR_EN
    logic        clr_bloom;
    localparam logic [CLR_W-1:0] CLR_SLOT_LAST  = CLR_W'((1 << SLOT_BITS) - 1);
    localparam logic [CLR_W-1:0] CLR_BLOOM_LAST = CLR_W'((1 << BLOOM_ADDR_BITS) - 1);
`else
    localparam logic [CLR_W-1:0] CLR_OCC_LAST   = CLR_W'((1 << TABLE_ADDR_BITS) - 1);
`endif

    logic                       occ_we;
    logic [TABLE_ADDR_BITS-1:0] occ_waddr;
    logic [OCC_W-1:0]           occ_wdata;
    logic [OCC_W-1:0]           occ_rdata;
    logic [TABLE_ADDR_BITS-1:0] bucket;
    logic                       occ_has_room;
    dict_entry_t                place_entry;
    logic [15:0]                hash_swap;
    logic [15:0]                hash_xor;
    logic                       unused_rdata;

    assign bucket       = hash_q[TABLE_ADDR_BITS-1:0];
    assign occ_has_room = occ_rdata < OCC_W'(CHAIN_DEPTH);
    assign place_entry  = '{valid: 1'b1, hash: hash_q, char_code: char_q, trans_ptr: ptr_q};
    assign hash_swap    = {hash_q[7:0], hash_q[15:8]};
    assign hash_xor     = hash_q ^ BLOOM_XOR_CONST;
    assign lookup_hold  = busy;
    assign unused_rdata = ^mem_rdata[31:24];

    // Occupancy writes: zeroing during the clear sweep, bump on a successful placement.
    always_comb begin
        occ_we    = 1'b0;
        occ_waddr = bucket;
        occ_wdata = occ_rdata + 1'b1;
        if (state == OCC_CLR) begin
`ifdef DLS_TABLE_CLEAR_EN
            occ_we    = !clr_bloom;
            occ_waddr = clr_cnt[SLOT_BITS-1:CD_BITS];
`else
            occ_we    = 1'b1;
            occ_waddr = clr_cnt[TABLE_ADDR_BITS-1:0];
`endif
            occ_wdata = '0;
        end else if (state == PLACE) begin
            occ_we = occ_has_room;
        end
    end

    bucket_occ_ram #(
        .ADDR_BITS (TABLE_ADDR_BITS),
        .DATA_BITS (OCC_W)
    ) u_occ (
        .clk   (clk),
        .we    (occ_we),
        .waddr (occ_waddr),
        .wdata (occ_wdata),
        .raddr (bucket),
        .rdata (occ_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            overflow        <= 1'b0;
            entries_loaded  <= '0;
            entries_dropped <= '0;
            mem_rd          <= 1'b0;
            mem_addr        <= '0;
            dict_load_en    <= 1'b0;
            dict_load_addr  <= '0;
            dict_load_data  <= '0;
            bloom_load_en   <= 1'b0;
            bloom_load_addr <= '0;
            bloom_load_bit  <= 1'b0;
            rd_ptr          <= '0;
            cnt_lat         <= '0;
            proc_cnt        <= '0;
            hash_q          <= '0;
            char_q          <= '0;
            ptr_q           <= '0;
            clr_cnt         <= '0;
`ifdef DLS_TABLE_CLEAR_EN
            clr_bloom       <= 1'b0;
`endif
        end else begin
            mem_rd        <= 1'b0;
            dict_load_en  <= 1'b0;
            bloom_load_en <= 1'b0;
            done          <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state           <= OCC_CLR;
                        busy            <= 1'b1;
                        overflow        <= 1'b0;
                        entries_loaded  <= '0;
                        entries_dropped <= '0;
                        proc_cnt        <= '0;
                        cnt_lat         <= entry_count;
                        rd_ptr          <= base_addr;
                        clr_cnt         <= '0;
`ifdef DLS_TABLE_CLEAR_EN
                        clr_bloom       <= 1'b0;
`endif
                    end
                end
                OCC_CLR: begin
`ifdef DLS_TABLE_CLEAR_EN
                    if (!clr_bloom) begin
                        dict_load_en   <= 1'b1;
                        dict_load_addr <= 16'(clr_cnt);
                        dict_load_data <= '0;
                        clr_cnt        <= (clr_cnt == CLR_SLOT_LAST) ? '0 : clr_cnt + 1'b1;
                        clr_bloom      <= (clr_cnt == CLR_SLOT_LAST);
                    end else begin
                        bloom_load_en   <= 1'b1;
                        bloom_load_addr <= 16'(clr_cnt);
                        bloom_load_bit  <= 1'b0;
                        if (clr_cnt == CLR_BLOOM_LAST) begin
                            clr_cnt   <= '0;
                            clr_bloom <= 1'b0;
                            state     <= (cnt_lat == 16'd0) ? FIN : FETCH0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
`else
                    if (clr_cnt == CLR_OCC_LAST) begin
                        clr_cnt <= '0;
                        state   <= (cnt_lat == 16'd0) ? FIN : FETCH0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
`endif
                end
                FETCH0: begin
                    mem_rd   <= 1'b1;
                    mem_addr <= rd_ptr;
                    rd_ptr   <= rd_ptr + 24'd1;
                    state    <= WAIT0;
                end
                WAIT0: begin
                    if (mem_rvalid) begin
                        hash_q <= mem_rdata[W0_HASH_LSB +: 16];
                        char_q <= mem_rdata[W0_CHAR_LSB +: 8];
                        state  <= FETCH1;
                    end
                end
                FETCH1: begin
                    mem_rd   <= 1'b1;
                    mem_addr <= rd_ptr;
                    rd_ptr   <= rd_ptr + 24'd1;
                    state    <= WAIT1;
                end
                WAIT1: begin
                    if (mem_rvalid) begin
                        ptr_q <= mem_rdata[W1_PTR_LSB +: 16];
                        state <= PLACE;
                    end
                end
                PLACE: begin
                    proc_cnt <= proc_cnt + 16'd1;
                    if (occ_has_room) begin
                        dict_load_en   <= 1'b1;
                        dict_load_addr <= 16'({bucket, occ_rdata[CD_BITS-1:0]});
                        dict_load_data <= place_entry;
                        entries_loaded <= sat_inc16(entries_loaded);
                        state          <= BLM1;
                    end else begin
                        entries_dropped <= sat_inc16(entries_dropped);
                        overflow        <= 1'b1;
                        state           <= NEXT;
                    end
                end
                BLM1: begin
                    bloom_load_en   <= 1'b1;
                    bloom_load_addr <= hash_q & BLOOM_MASK;
                    bloom_load_bit  <= 1'b1;
                    state           <= BLM2;
                end
                BLM2: begin
                    bloom_load_en   <= 1'b1;
                    bloom_load_addr <= hash_swap & BLOOM_MASK;
                    bloom_load_bit  <= 1'b1;
                    state           <= BLM3;
                end
                BLM3: begin
                    bloom_load_en   <= 1'b1;
                    bloom_load_addr <= hash_xor & BLOOM_MASK;
                    bloom_load_bit  <= 1'b1;
                    state           <= NEXT;
                end
                NEXT: begin
                    state <= (proc_cnt < cnt_lat) ? FETCH0 : FIN;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dict_load_sequencer.sv
// Scoreboard bench for dict_load_sequencer: a reference model queues expected reads and
// table/bloom writes per load; a negedge monitor pops and compares as the DUT strobes them.
module tb_dict_load_sequencer;

    localparam int TABLE_BITS = 8;
    localparam int CHAIN      = 4;
    localparam int BLOOM_BITS = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] base_addr = '0;
    logic [15:0] entry_count = '0;
    logic        busy, done, overflow, lookup_hold;
    logic [15:0] entries_loaded, entries_dropped;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        dict_load_en;
    logic [15:0] dict_load_addr;
    logic [40:0] dict_load_data;
    logic        bloom_load_en;
    logic [15:0] bloom_load_addr;
    logic        bloom_load_bit;

    always #5 clk = ~clk;

    dict_load_sequencer #(
        .BLOOM_ADDR_BITS (BLOOM_BITS),
        .TABLE_ADDR_BITS (TABLE_BITS),
        .CHAIN_DEPTH     (CHAIN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .base_addr       (base_addr),
        .entry_count     (entry_count),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .entries_loaded  (entries_loaded),
        .entries_dropped (entries_dropped),
        .lookup_hold     (lookup_hold),
        .mem_rd          (mem_rd),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid),
        .dict_load_en    (dict_load_en),
        .dict_load_addr  (dict_load_addr),
        .dict_load_data  (dict_load_data),
        .bloom_load_en   (bloom_load_en),
        .bloom_load_addr (bloom_load_addr),
        .bloom_load_bit  (bloom_load_bit)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;

    logic [31:0] mem_img [logic [23:0]];
    logic [23:0] exp_rd [$];
    logic [15:0] exp_dict_addr [$];
    logic [40:0] exp_dict_data [$];
    logic [15:0] exp_bloom_addr [$];
    logic        exp_bloom_bit [$];
    logic [15:0] ent_hash [$];
    logic [7:0]  ent_char [$];
    logic [15:0] ent_ptr [$];
    int          exp_loaded;
    int          exp_dropped;
    logic        exp_overflow;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] readMem(input logic [23:0] a);
        return mem_img.exists(a) ? mem_img[a] : 32'h0;
    endfunction

    // Memory responder: one data beat two cycles after each read request.
    initial begin
        int          rsp_cnt;
        logic [23:0] rsp_addr;
        rsp_cnt    = 0;
        rsp_addr   = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hDEADBEEF;
            if (!rst_n) begin
                rsp_cnt = 0;
            end else if (rsp_cnt != 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = readMem(rsp_addr);
                end
            end
            if (rst_n && mem_rd) begin
                rsp_addr = mem_addr;
                rsp_cnt  = 2;
            end
        end
    end

    // Scoreboard monitor: every strobe must match the head of its expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("strobe_excl", 64'(dict_load_en & bloom_load_en), 0);
                if (mem_rd) begin
                    if (exp_rd.size() == 0) checkOutput("rd_unexpected", mem_addr, 64'hFFFF_FFFF);
                    else checkOutput("rd_addr", mem_addr, exp_rd.pop_front());
                end
                if (dict_load_en) begin
                    if (exp_dict_addr.size() == 0) checkOutput("dict_unexpected", dict_load_addr, 64'hFFFF_FFFF);
                    else begin
                        checkOutput("dict_addr", dict_load_addr, exp_dict_addr.pop_front());
                        checkOutput("dict_data", dict_load_data, exp_dict_data.pop_front());
                    end
                end
                if (bloom_load_en) begin
                    if (exp_bloom_addr.size() == 0) checkOutput("bloom_unexpected", bloom_load_addr, 64'hFFFF_FFFF);
                    else begin
                        checkOutput("bloom_addr", bloom_load_addr, exp_bloom_addr.pop_front());
                        checkOutput("bloom_bit", bloom_load_bit, exp_bloom_bit.pop_front());
                    end
                end
                if (done) begin
                    done_seen++;
                    checkOutput("busy_in_done", busy, 0);
                end
            end
        end
    end

    task automatic flushQueues();
        exp_rd.delete();
        exp_dict_addr.delete();
        exp_dict_data.delete();
        exp_bloom_addr.delete();
        exp_bloom_bit.delete();
    endtask

    // Builds the memory image and expectations from ent_* for count entries, then pulses start.
    task automatic applyStimulus(input logic [23:0] base, input int count);
        int          occ_m [256];
        logic [23:0] a0, a1;
        logic [15:0] h, p;
        logic [7:0]  c, bkt;
        for (int i = 0; i < 256; i++) occ_m[i] = 0;
        exp_loaded   = 0;
        exp_dropped  = 0;
        exp_overflow = 1'b0;
`ifdef DLS_TABLE_CLEAR_EN
        for (int s = 0; s < (1 << TABLE_BITS) * CHAIN; s++) begin
            exp_dict_addr.push_back(16'(s));
            exp_dict_data.push_back('0);
        end
        for (int b = 0; b < (1 << BLOOM_BITS); b++) begin
            exp_bloom_addr.push_back(16'(b));
            exp_bloom_bit.push_back(1'b0);
        end
`endif
        for (int k = 0; k < count; k++) begin
            h  = ent_hash[k];
            c  = ent_char[k];
            p  = ent_ptr[k];
            a0 = base + 24'(2 * k);
            a1 = a0 + 24'd1;
            mem_img[a0] = {8'h00, c, h};
            mem_img[a1] = {16'h0000, p};
            exp_rd.push_back(a0);
            exp_rd.push_back(a1);
            bkt = h[7:0];
            if (occ_m[bkt] < CHAIN) begin
                exp_dict_addr.push_back(16'(int'(bkt) * CHAIN + occ_m[bkt]));
                exp_dict_data.push_back({1'b1, h, c, p});
                exp_bloom_addr.push_back(h & 16'h03FF);
                exp_bloom_addr.push_back({h[7:0], h[15:8]} & 16'h03FF);
                exp_bloom_addr.push_back((h ^ 16'h5A5A) & 16'h03FF);
                repeat (3) exp_bloom_bit.push_back(1'b1);
                occ_m[bkt]++;
                exp_loaded++;
            end else begin
                exp_dropped++;
                exp_overflow = 1'b1;
            end
        end
        done_seen   = 0;
        base_addr   = base;
        entry_count = 16'(count);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic waitForDone(input string tag);
        int cyc = 0;
        while (done_seen == 0 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_done"}, 64'(done_seen != 0), 1);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_done_once"}, done_seen, 1);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_hold"}, lookup_hold, 0);
        checkOutput({tag, "_loaded"}, entries_loaded, exp_loaded);
        checkOutput({tag, "_dropped"}, entries_dropped, exp_dropped);
        checkOutput({tag, "_overflow"}, overflow, exp_overflow);
        checkOutput({tag, "_rd_left"}, exp_rd.size(), 0);
        checkOutput({tag, "_dict_left"}, exp_dict_addr.size(), 0);
        checkOutput({tag, "_bloom_left"}, exp_bloom_addr.size(), 0);
    endtask

    task automatic setEntries(input int n, input logic [15:0] h0, input logic [15:0] hstep);
        ent_hash.delete();
        ent_char.delete();
        ent_ptr.delete();
        for (int i = 0; i < n; i++) begin
            ent_hash.push_back(h0 + 16'(i) * hstep);
            ent_char.push_back(8'h41 + 8'(i));
            ent_ptr.push_back(16'h0100 + 16'(i));
        end
    endtask

    initial begin
        int cyc;
        $display("[TB] reset check");
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_hold", lookup_hold, 0);
        checkOutput("rst_mem_rd", mem_rd, 0);
        checkOutput("rst_counts", {entries_loaded, entries_dropped, 7'(overflow)}, 0);
        checkOutput("rst_strobes", {dict_load_en, bloom_load_en, bloom_load_bit}, 0);
        checkOutput("rst_dict_data", dict_load_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single entry");
        setEntries(1, 16'h1234, 16'h0);
        applyStimulus(24'h000100, 1);
        waitForDone("single");

        $display("[TB] chain overflow");
        setEntries(5, 16'h0034, 16'h1100);
        applyStimulus(24'h001000, 5);
        waitForDone("chain");

        $display("[TB] zero entries");
        applyStimulus(24'h000200, 0);
        waitForDone("zero");

        $display("[TB] reset during WAIT1");
        setEntries(2, 16'h0A55, 16'h0101);
        applyStimulus(24'h002000, 2);
        cyc = 0;
        while (!(mem_rd && mem_addr == 24'h002001) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("mid_reach_wait1", 64'(mem_rd && mem_addr == 24'h002001), 1);
        checkOutput("mid_hold", lookup_hold, 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_hold", lookup_hold, 0);
        checkOutput("mid_rst_mem", {mem_rd, mem_addr}, 0);
        checkOutput("mid_rst_strobes", {dict_load_en, bloom_load_en, done}, 0);
        flushQueues();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(24'h002000, 2);
        waitForDone("after_rst");

        $display("[TB] address wrap and ignored restart");
        setEntries(1, 16'hBEEF, 16'h0);
        applyStimulus(24'hFFFFFF, 1);
        repeat (20) @(negedge clk);
        base_addr   = 24'h123456;
        entry_count = 16'd3;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        waitForDone("wrap");

        $display("[TB] colliding buckets");
        ent_hash.delete();
        ent_char.delete();
        ent_ptr.delete();
        for (int i = 0; i < 12; i++) begin
            ent_hash.push_back({8'($urandom_range(0, 255)), 8'h40 + 8'($urandom_range(0, 2))});
            ent_char.push_back(8'($urandom_range(0, 255)));
            ent_ptr.push_back(16'($urandom_range(0, 65535)));
        end
        applyStimulus(24'h00ABC0, 12);
        waitForDone("collide");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dict_load_sequencer.md
DICT_LOAD_SEQUENCER -- requirements
Module: dict_load_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BLOOM_ADDR_BITS, 10, bloom bit-index width.
- TABLE_ADDR_BITS, 8, bucket-index width.
- CHAIN_DEPTH, 4, slots per bucket (power of 2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst_n, in, 1, reset: synchronous, active-low.
- start, in, 1, begin a load.
- base_addr, in, 24, first word of the dictionary image.
- entry_count, in, 16, number of entries to load.
- busy, out, 1, load in progress.
- done, out, 1, one-cycle completion pulse.
- overflow, out, 1, sticky: at least one entry was dropped.
- entries_loaded, out, 16, entries written to the table.
- entries_dropped, out, 16, entries dropped because their chain was full.
- lookup_hold, out, 1, lookup requesters must stall.
- mem_rd, out, 1, one-cycle read request.
- mem_addr, out, 24, read address.
- mem_rdata, in, 32, read data.
- mem_rvalid, in, 1, read data valid.
- dict_load_en, out, 1, table slot write strobe.
- dict_load_addr, out, 16, table slot address.
- dict_load_data, out, 41, table slot data.
- bloom_load_en, out, 1, bloom bit write strobe.
- bloom_load_addr, out, 16, bloom bit address.
- bloom_load_bit, out, 1, bloom bit value.

Function
REQ-003 An entry SHALL occupy two image words: word0 = {8'h0, char_code[23:16], hash[15:0]}; word1 = {16'h0, trans_ptr[15:0]}.
REQ-004 Entry k SHALL be read from base_addr+2k (word0) and base_addr+2k+1 (word1), with 24-bit wrap-around.
REQ-005 The state machine SHALL have these states: IDLE, OCC_CLR, FETCH0, WAIT0, FETCH1, WAIT1, PLACE, BLM1, BLM2, BLM3, NEXT, FIN.
REQ-006 start in IDLE SHALL move to OCC_CLR next cycle, clear overflow and both counters, and raise busy; start outside IDLE SHALL be ignored.
REQ-007 OCC_CLR SHALL zero one bucket-occupancy counter per cycle, taking 2^TABLE_ADDR_BITS cycles, then go to FETCH0, or to FIN if entry_count==0.
REQ-008 FETCH0/FETCH1 SHALL pulse mem_rd for exactly one cycle with mem_addr valid; WAIT0/WAIT1 SHALL hold until mem_rvalid, latch mem_rdata, then advance; mem_rvalid outside a WAIT state SHALL be ignored.
REQ-009 PLACE: bucket = hash[TABLE_ADDR_BITS-1:0] and occ = its occupancy count.
- If occ < CHAIN_DEPTH: pulse dict_load_en with addr = {bucket, occ[log2(CHAIN_DEPTH)-1:0]} zero-extended, data = {1'b1, hash, char_code, trans_ptr}; increment occ and entries_loaded.
- Otherwise: no write, increment entries_dropped, set overflow, go directly to NEXT (no bloom bits set).
REQ-010 BLM1/BLM2/BLM3 SHALL each pulse bloom_load_en with bit 1, at the low BLOOM_ADDR_BITS bits (zero-extended) of, respectively: hash; {hash[7:0], hash[15:8]}; hash ^ 16'h5A5A.
REQ-011 NEXT SHALL go to FETCH0 while the processed count < entry_count, else to FIN.
REQ-012 FIN SHALL pulse done for one cycle and return to IDLE; busy SHALL be low in the done cycle.
REQ-013 lookup_hold SHALL equal busy.
REQ-014 At most one of dict_load_en and bloom_load_en SHALL be high in any cycle.
REQ-015 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-016 With rst_n low at a clock edge:
- state SHALL go to IDLE and all outputs SHALL be 0, including mid-load.
- Partially loaded contents SHALL be left as written.

Configuration
REQ-017 DLS_TABLE_CLEAR_EN SHALL select the clear behaviour.
- Defined: OCC_CLR also writes every table slot with data 41'h0 (dict_load_en, 2^TABLE_ADDR_BITS*CHAIN_DEPTH cycles), then every bloom bit with 0 (2^BLOOM_ADDR_BITS cycles), before fetching.
- Undefined: only occupancy counters are cleared, and table/bloom contents are untouched.

Structure
REQ-018 Package dict_load_pkg SHALL hold the state enum, word field offsets, BLOOM_XOR_CONST=16'h5A5A and the 41-bit entry layout.
REQ-019 Occupancy storage SHALL be the sub-module bucket_occ_ram (2^TABLE_ADDR_BITS x log2(CHAIN_DEPTH)+1 bits, 1 read / 1 write per cycle).

Verification
REQ-020 entry_count=1, hash 16'h1234, char 8'h41, ptr 16'h0100, mem_rvalid 2 cycles after each mem_rd -> dict write addr 16'h00D0, data {1,1234,41,0100}; bloom addrs 16'h0234, 16'h0012, 16'h006E; done once; entries_loaded=1.
REQ-021 5 entries all with hash[7:0]=8'h34 -> slots 00D0..00D3 written; 5th dropped; overflow=1; entries_dropped=1; entries_loaded=4.
REQ-022 entry_count=0 -> done immediately after OCC_CLR; no mem_rd, no load strobes.
REQ-023 rst_n low while in WAIT1 -> all outputs 0 next cycle; a fresh start then loads correctly.
REQ-024 start pulsed while busy -> ignored; base_addr 24'hFFFFFF, 1 entry -> reads at FFFFFF then 000000.
REQ-025 With DLS_TABLE_CLEAR_EN defined and defaults -> 1024 zero table writes then 1024 zero bloom writes precede the first mem_rd.
